core_sequencer: RTL and testbench

Multi-cycle control FSM sitting between the main instruction decoder and the datapath of the 9-bit-instruction core. It steps each instruction through fetch, decode, optional data-memory access with a request/acknowledge handshake, and writeback. It gates the decoder's static control lines into single-cycle strobes and counts retired instructions. It also detects the halt opcode and reports completion to the test harness.

---
 rtl/core_sequencer_if.sv | 34 +++
 rtl/core_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_core_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_sequencer_if.sv
// Control bundle between core_sequencer and its decoder/datapath/data-memory neighbours.
// master = sequencer side (drives strobes); slave = environment side (drives start, op, decoder lines, ack).
interface core_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [5:0]       op;
  logic             reg_write_dec;
  logic             mem_write_dec;
  logic             mem_to_reg_dec;
  logic             dmem_ack;
  logic             pc_clear;
  logic             ir_load;
  logic             pc_load;
  logic             reg_we;
  logic             dmem_req;
  logic             dmem_we;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] instr_count;
  logic             timeout_err;

  modport master (
    input  start, op, reg_write_dec, mem_write_dec, mem_to_reg_dec, dmem_ack,
    output pc_clear, ir_load, pc_load, reg_we, dmem_req, dmem_we, busy, done,
           instr_count, timeout_err
  );

  modport slave (
    output start, op, reg_write_dec, mem_write_dec, mem_to_reg_dec, dmem_ack,
    input  pc_clear, ir_load, pc_load, reg_we, dmem_req, dmem_we, busy, done,
           instr_count, timeout_err
  );
endinterface

// File: rtl/core_sequencer.sv
// Instruction-stepping FSM: 3 cycles per ALU op, 4+W per memory op (W = ack wait); start ignored while busy.
// dmem_req holds until dmem_ack; with SEQ_TIMEOUT_EN defined a stalled access aborts to HALT with timeout_err.
module core_sequencer #(
  parameter logic [5:0] HALT_OP     = 6'b111111,
  parameter int         CNT_W       = 16,
  parameter int         MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  core_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             start_ok;
  logic             mem_tmo;
  logic             pc_clear_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_err;

  logic             ir_load;
  logic             pc_load;
  logic             reg_we;
  logic             dmem_req;
  logic             dmem_we;
  logic             busy;
  logic             done;

  assign start_ok = bus.start & ((state == S_IDLE) | (state == S_HALT));

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_err_q;

  // Held at zero outside MEM, so every MEM entry starts a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state != S_MEM) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign mem_tmo = (state == S_MEM) & ~bus.dmem_ack & (tmo_cnt == TW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_err_q <= 1'b0;
    end else if (start_ok) begin
      tmo_err_q <= 1'b0;
    end else if (mem_tmo) begin
      tmo_err_q <= 1'b1;
    end
  end

  assign tmo_err = tmo_err_q;
`else
  logic unused_tmo_cfg;

  assign unused_tmo_cfg = ^MEM_TIMEOUT;
  assign mem_tmo        = 1'b0;
  assign tmo_err        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; halt opcode wins over the decoder's memory controls.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start_ok) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        if (bus.op == HALT_OP) begin
          state_nx = S_HALT;
        end else if (bus.mem_to_reg_dec | bus.mem_write_dec) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          state_nx = S_WB;
        end else if (mem_tmo) begin
          state_nx = S_HALT;
        end
      end
      S_WB:     state_nx = S_FETCH;
      S_HALT:   if (start_ok) state_nx = S_FETCH;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Output decode: Moore strobes, dmem_we additionally qualified by the store control.
  always_comb begin
    ir_load  = 1'b0;
    pc_load  = 1'b0;
    reg_we   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_FETCH: begin
        ir_load = 1'b1;
        busy    = 1'b1;
      end
      S_DECODE: begin
        busy = 1'b1;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = bus.mem_write_dec;
        busy     = 1'b1;
      end
      S_WB: begin
        pc_load = 1'b1;
        reg_we  = bus.reg_write_dec;
        busy    = 1'b1;
      end
      S_HALT: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // pc_clear lines up with the first FETCH after an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_clear_q <= 1'b0;
    end else begin
      pc_clear_q <= start_ok;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (start_ok) begin
      cnt_q <= '0;
    end else if ((state == S_WB) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_clear    = pc_clear_q;
  assign bus.ir_load     = ir_load;
  assign bus.pc_load     = pc_load;
  assign bus.reg_we      = reg_we;
  assign bus.dmem_req    = dmem_req;
  assign bus.dmem_we     = dmem_we;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.instr_count = cnt_q;
  assign bus.timeout_err = tmo_err;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: per-instruction expectations queued by the driver, checked by a monitor.
module tb_core_sequencer;

  localparam logic [5:0] HALT_OP     = 6'b111111;
  localparam int         CNT_W       = 16;
  localparam int         MEM_TIMEOUT = 15;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_HALT  = 3;
  localparam int K_STALL = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  core_sequencer_if #(.CNT_W(CNT_W)) sif ();

  core_sequencer #(
    .HALT_OP    (HALT_OP),
    .CNT_W      (CNT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (sif)
  );

  typedef struct {
    bit tmo;
    int lat;
    int reqs;
    bit we;
    int regwe;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   exp_first = 1'b0;
  int   model_cnt = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_pc_clear"},    int'(sif.pc_clear), 0);
    chk({tag, "_ir_load"},     int'(sif.ir_load), 0);
    chk({tag, "_pc_load"},     int'(sif.pc_load), 0);
    chk({tag, "_reg_we"},      int'(sif.reg_we), 0);
    chk({tag, "_dmem_req"},    int'(sif.dmem_req), 0);
    chk({tag, "_dmem_we"},     int'(sif.dmem_we), 0);
    chk({tag, "_busy"},        int'(sif.busy), 0);
    chk({tag, "_done"},        int'(sif.done), 0);
    chk({tag, "_instr_count"}, int'(sif.instr_count), 0);
    chk({tag, "_timeout_err"}, int'(sif.timeout_err), 0);
  endtask

  // Monitor: accumulates what each instruction did between its FETCH and its retirement.
  int m_cyc = 0;
  int m_reqs = 0;
  int m_regwe = 0;
  bit m_we = 1'b0;
  bit m_done_prev = 1'b0;
  bit m_cnt_pend = 1'b0;
  int m_cnt_exp = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_done_prev = 1'b0;
        m_cnt_pend  = 1'b0;
        m_cyc       = 0;
      end else begin
        if (m_cnt_pend) begin
          chk("count_after_wb", int'(sif.instr_count), m_cnt_exp);
          m_cnt_pend = 1'b0;
        end
        if (sif.ir_load) begin
          chk("pc_clear_at_fetch", int'(sif.pc_clear), int'(exp_first));
          chk("timeout_err_at_fetch", int'(sif.timeout_err), 0);
          exp_first = 1'b0;
          m_cyc   = 1;
          m_reqs  = 0;
          m_regwe = 0;
          m_we    = 1'b0;
        end else begin
          m_cyc++;
        end
        chk("pc_clear_outside_fetch", int'(sif.pc_clear & ~sif.ir_load), 0);
        chk("dmem_we_without_req", int'(sif.dmem_we & ~sif.dmem_req), 0);
        chk("busy_and_done", int'(sif.busy & sif.done), 0);
        if (sif.dmem_req) begin
          m_reqs++;
          m_we = m_we | sif.dmem_we;
        end
        if (sif.reg_we) m_regwe++;
        if (sif.pc_load) begin
          chk("wb_expected", int'(q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("instr_latency", m_cyc, e.lat);
            chk("dmem_req_cycles", m_reqs, e.reqs);
            chk("dmem_we_seen", int'(m_we), int'(e.we));
            chk("reg_we_pulses", m_regwe, e.regwe);
            m_cnt_pend = 1'b1;
            m_cnt_exp  = e.cnt;
          end
        end
        if (sif.done && !m_done_prev) begin
          chk("halt_expected", int'(q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("halt_latency", m_cyc, e.lat);
            chk("halt_dmem_req_cycles", m_reqs, e.reqs);
            chk("halt_reg_we", m_regwe, e.regwe);
            chk("halt_instr_count", int'(sif.instr_count), e.cnt);
            chk("halt_timeout_err", int'(sif.timeout_err), int'(e.tmo));
          end
        end
        m_done_prev = sif.done;
      end
    end
  end

  task automatic do_start();
    exp_first = 1'b1;
    model_cnt = 0;
    sif.start = 1'b1;
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      sif.start = 1'b0;
      if (sif.ir_load) begin
        ok = 1'b1;
        break;
      end
    end
    chk("fetch_seen", int'(ok), 1);
  endtask

  // Drives one instruction from its FETCH to its retirement and queues what it should do.
  task automatic run_instr(input int kind, input int w, input bit reset_mid);
    bit   ok;
    bit   rw, mw, mr, mem;
    exp_t e;
    wait_fetch(ok);
    if (!ok) return;
    rw = ($urandom_range(0, 3) != 0);
    mw = 1'b0;
    mr = 1'b0;
    case (kind)
      K_LOAD:  begin rw = 1'b1; mr = 1'b1; end
      K_STORE: begin rw = 1'b0; mw = 1'b1; end
      K_HALT:  begin mw = 1'($urandom_range(0, 1)); mr = 1'($urandom_range(0, 1)); end
      K_STALL: begin mw = 1'($urandom_range(0, 1)); mr = ~mw; end
      default: ;
    endcase
    mem = (kind == K_LOAD) || (kind == K_STORE) || (kind == K_STALL);
    sif.op             = (kind == K_HALT) ? HALT_OP : 6'($urandom_range(0, 62));
    sif.reg_write_dec  = rw;
    sif.mem_write_dec  = mw;
    sif.mem_to_reg_dec = mr;

    if ((kind == K_ALU) || (kind == K_LOAD) || (kind == K_STORE)) begin
      if (model_cnt < (1 << CNT_W) - 1) model_cnt++;
    end
    e.tmo   = (kind == K_STALL);
    e.lat   = (kind == K_STALL) ? 3 + MEM_TIMEOUT : (mem ? 4 + w : 3);
    e.reqs  = (kind == K_STALL) ? MEM_TIMEOUT : (mem ? w + 1 : 0);
    e.we    = mem && mw;
    e.regwe = ((kind == K_ALU) || (kind == K_LOAD) || (kind == K_STORE)) ? int'(rw) : 0;
    e.cnt   = model_cnt;
    q.push_back(e);

    @(negedge clk);
    sif.dmem_ack = ($urandom_range(0, 2) == 0);
    @(negedge clk);
    sif.dmem_ack = 1'b0;

    if (reset_mid) begin
      chk("req_before_reset", int'(sif.dmem_req), 1);
      reset = 1'b1;
      #1;
      check_all_zero("mid_reset");
      q.delete();
      model_cnt = 0;
      @(negedge clk);
      reset = 1'b0;
    end else if (kind == K_STALL) begin
      repeat (MEM_TIMEOUT) @(negedge clk);
    end else if (mem) begin
      for (int i = 0; i < w; i++) begin
        sif.start = ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
      sif.start    = 1'b0;
      sif.dmem_ack = 1'b1;
      @(negedge clk);
      sif.dmem_ack = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.start          = 1'b0;
    sif.op             = 6'd0;
    sif.reg_write_dec  = 1'b0;
    sif.mem_write_dec  = 1'b0;
    sif.mem_to_reg_dec = 1'b0;
    sif.dmem_ack       = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    // Three ALU ops then halt.
    do_start();
    for (int i = 0; i < 3; i++) run_instr(K_ALU, 0, 1'b0);
    run_instr(K_HALT, 0, 1'b0);

    // Load with two wait cycles, store with same-cycle ack.
    do_start();
    run_instr(K_LOAD, 2, 1'b0);
    run_instr(K_STORE, 0, 1'b0);
    run_instr(K_HALT, 0, 1'b0);

    // Random programs.
    for (int p = 0; p < 10; p++) begin
      int n;
      n = $urandom_range(2, 8);
      do_start();
      for (int i = 0; i < n; i++) run_instr($urandom_range(0, 2), $urandom_range(0, 5), 1'b0);
      run_instr(K_HALT, 0, 1'b0);
    end

    // Reset in the middle of a memory access, then a clean run from count 0.
    do_start();
    run_instr(K_ALU, 0, 1'b0);
    run_instr(K_LOAD, 3, 1'b1);
    do_start();
    run_instr(K_ALU, 0, 1'b0);
    run_instr(K_STORE, 1, 1'b0);
    run_instr(K_HALT, 0, 1'b0);

`ifdef SEQ_TIMEOUT_EN
    do_start();
    run_instr(K_ALU, 0, 1'b0);
    run_instr(K_STALL, 0, 1'b0);
    @(negedge clk);
    chk("timeout_err_sticky", int'(sif.timeout_err), 1);
    do_start();
    run_instr(K_ALU, 0, 1'b0);
    run_instr(K_HALT, 0, 1'b0);
`endif

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
